sprite_mem_arbiter: RTL and testbench

Arbiter and sequencer for the 16×32 single-port sprite/state RAM. The RAM has one port, a write enable and a 1-cycle registered read. This block shares that port between two requesters: the host-bus side (HPS register writes and readback) and the VGA display pipeline (sprite fetch reads). It issues at most one RAM access per cycle. It gives the display priority with bounded host starvation, tracks in-flight reads, and returns read data to the correct requester in holding registers.

---
 rtl/sprite_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_sprite_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter
// Shares the single port of the sprite/state RAM between the host bus and the
// display pipeline. The display has priority, and a host request that waits too
// long is forced through. Read results are returned to the requester that
// issued the read, in a holding register with a one-cycle valid pulse.

module sprite_mem_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDR_BITS    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_ack,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic                 host_rvalid,

  input  logic                 disp_req,
  input  logic [ADDR_BITS-1:0] disp_addr,
  output logic                 disp_gnt,
  output logic [WORD_SIZE-1:0] disp_rdata,
  output logic                 disp_rvalid,

  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data_in,
  input  logic [WORD_SIZE-1:0] mem_data_out
);

  localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_BITS-1:0] STARVE_MAX = CNT_BITS'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_HOST,
    GNT_DISP
  } grant_t;

  grant_t              grant;
  logic [CNT_BITS-1:0] starve_cnt;
  logic                host_force;
  logic                rd_issue;
  logic                rd_pend;
  logic                rd_owner_host;

  assign host_force = host_req && (starve_cnt >= STARVE_MAX);

  // Pick this cycle's single RAM user: forced host, then display, then host.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned and a latch cannot be inferred.
    grant = GNT_NONE;
    if (reset) begin
      grant = GNT_NONE;
    end else if (host_force) begin
      grant = GNT_HOST;
    end else if (disp_req) begin
      grant = GNT_DISP;
    end else if (host_req) begin
      grant = GNT_HOST;
    end
  end

  // Steer the granted requester onto the RAM port; idle drives all zeros.
  always_comb begin
    host_ack    = 1'b0;
    disp_gnt    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    rd_issue    = 1'b0;
    case (grant)
      GNT_HOST: begin
        host_ack    = 1'b1;
        mem_we      = host_we;
        mem_addr    = host_addr;
        mem_data_in = host_wdata;
        rd_issue    = !host_we;
      end
      GNT_DISP: begin
        disp_gnt = 1'b1;
        mem_addr = disp_addr;
        rd_issue = 1'b1;
      end
      default: begin
        rd_issue = 1'b0;
      end
    endcase
  end

  // Count consecutive refused cycles of a pending host request, saturating.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      starve_cnt <= '0;
    end else if (host_req && !host_ack) begin
      if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + CNT_BITS'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Remember whether a read went out this cycle and who issued it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend       <= 1'b0;
      rd_owner_host <= 1'b0;
    end else begin
      rd_pend       <= rd_issue;
      rd_owner_host <= (grant == GNT_HOST);
    end
  end

  // Capture returning RAM data into the owner's holding register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the holding registers are plain flops, not a memory array, so they
    // are reset so that both requesters see a defined zero after reset.
    if (reset) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      disp_rdata  <= '0;
      disp_rvalid <= 1'b0;
    end else begin
      host_rvalid <= rd_pend && rd_owner_host;
      disp_rvalid <= rd_pend && !rd_owner_host;
      if (rd_pend && rd_owner_host) begin
        host_rdata <= mem_data_out;
      end
      if (rd_pend && !rd_owner_host) begin
        disp_rdata <= mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Bench for sprite_mem_arbiter: a behavioural 16x32 RAM with registered read,
// a per-cycle arbitration vector table, and hand-written multi-cycle sequences.

module tb_sprite_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_req;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        disp_req;
  logic [3:0]  disp_addr;
  logic        disp_gnt;
  logic [31:0] disp_rdata;
  logic        disp_rvalid;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_mem_arbiter #(
    .WORD_SIZE   (32),
    .ADDR_BITS   (4),
    .STARVE_LIMIT(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .disp_rdata  (disp_rdata),
    .disp_rvalid (disp_rvalid),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // RAM model: preloaded with addr*0x11 on the first edge, registered read.
  logic [31:0] ram [16];
  bit          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'(i) * 32'h11;
      loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_data_in;
    end
    mem_data_out <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    disp_req   = 1'b0;
    disp_addr  = '0;
  endtask

  typedef struct {
    logic        hreq;
    logic        hwe;
    logic [3:0]  haddr;
    logic [31:0] hwdata;
    logic        dreq;
    logic [3:0]  daddr;
    logic        hack;
    logic        dgnt;
    logic        mwe;
    logic [3:0]  maddr;
    logic [31:0] mdin;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Consecutive cycles; the starvation counter carries from row to row.
    //          hreq  hwe   haddr  hwdata        dreq  daddr  hack  dgnt  mwe   maddr  mdin
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 4'h0,  1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 4'h5, 32'h0BADF00D, 1'b0, 4'h0,  1'b1, 1'b0, 1'b1, 4'h5, 32'h0BADF00D};
    vecs[2] = '{1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 4'h9,  1'b0, 1'b1, 1'b0, 4'h9, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 4'hE, 32'h12345678, 1'b1, 4'h3,  1'b0, 1'b1, 1'b0, 4'h3, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 4'hE, 32'h12345678, 1'b1, 4'h4,  1'b0, 1'b1, 1'b0, 4'h4, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 4'h4,  1'b0, 1'b1, 1'b0, 4'h4, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 4'h6, 32'h0,        1'b1, 4'h8,  1'b0, 1'b1, 1'b0, 4'h8, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 4'h6, 32'h0,        1'b0, 4'h0,  1'b1, 1'b0, 1'b0, 4'h6, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 4'h0,  1'b0, 1'b0, 1'b0, 4'h0, 32'h0};

    // Reset with both requesters asking: nothing granted, outputs cleared.
    reset      = 1'b1;
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 4'h5;
    host_wdata = 32'h11111111;
    disp_req   = 1'b1;
    disp_addr  = 4'h2;
    advance();
    advance();
    settle();
    check("rst_host_ack",    host_ack,    0);
    check("rst_disp_gnt",    disp_gnt,    0);
    check("rst_mem_we",      mem_we,      0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_disp_rvalid", disp_rvalid, 0);
    check("rst_host_rdata",  host_rdata,  0);
    check("rst_disp_rdata",  disp_rdata,  0);
    advance();
    reset = 1'b0;
    settle();
    check("rel_disp_gnt", disp_gnt, 1);
    check("rel_host_ack", host_ack, 0);
    check("rel_mem_addr", mem_addr, 32'h2);
    advance();
    idle_inputs();

    // Per-cycle arbitration table.
    for (int i = 0; i < 9; i++) begin
      host_req   = vecs[i].hreq;
      host_we    = vecs[i].hwe;
      host_addr  = vecs[i].haddr;
      host_wdata = vecs[i].hwdata;
      disp_req   = vecs[i].dreq;
      disp_addr  = vecs[i].daddr;
      settle();
      check($sformatf("vec%0d_host_ack", i), host_ack, vecs[i].hack);
      check($sformatf("vec%0d_disp_gnt", i), disp_gnt, vecs[i].dgnt);
      check($sformatf("vec%0d_mem_we",   i), mem_we,   vecs[i].mwe);
      check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].maddr);
      if (vecs[i].hack) check($sformatf("vec%0d_mem_data_in", i), mem_data_in, vecs[i].mdin);
      advance();
    end
    idle_inputs();
    advance();
    advance();

    // Host write then read of the same address.
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'h5; host_wdata = 32'hDEADBEEF;
    settle();
    check("wr_host_ack", host_ack, 1);
    check("wr_mem_we",   mem_we,   1);
    advance();
    host_we = 1'b0; host_wdata = '0;
    settle();
    check("rd_host_ack", host_ack, 1);
    check("rd_mem_we",   mem_we,   0);
    check("rd_mem_addr", mem_addr, 32'h5);
    advance();
    idle_inputs();
    settle();
    check("rd_n1_host_rvalid", host_rvalid, 0);
    advance();
    settle();
    check("rd_n2_host_rvalid", host_rvalid, 1);
    check("rd_n2_host_rdata",  host_rdata,  32'hDEADBEEF);
    check("rd_n2_disp_rvalid", disp_rvalid, 0);
    advance();
    settle();
    check("rd_n3_host_rvalid", host_rvalid, 0);
    check("rd_n3_host_rdata",  host_rdata,  32'hDEADBEEF);
    check("rd_n3_disp_rvalid", disp_rvalid, 0);
    advance();

    // Starvation: display held, host read raised in cycle 0, forced in cycle 4.
    for (int c = 0; c < 6; c++) begin
      disp_req  = 1'b1;
      disp_addr = 4'(c);
      host_req  = (c <= 4);
      host_we   = 1'b0;
      host_addr = 4'hA;
      settle();
      check($sformatf("starve_c%0d_disp_gnt", c), disp_gnt, (c != 4));
      check($sformatf("starve_c%0d_host_ack", c), host_ack, (c == 4));
      advance();
    end
    idle_inputs();
    settle();
    check("starve_cnt_cleared",  dut.starve_cnt, 0);
    check("starve_host_rvalid",  host_rvalid,    1);
    check("starve_host_rdata",   host_rdata,     32'hAA);
    advance();
    advance();
    advance();

    // Interleaved reads: display 1, display 2, host 3.
    disp_req = 1'b1; disp_addr = 4'h1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'h3;
    settle();
    check("ilv_c0_disp_gnt", disp_gnt, 1);
    check("ilv_c0_host_ack", host_ack, 0);
    advance();
    disp_addr = 4'h2;
    settle();
    check("ilv_c1_disp_gnt", disp_gnt, 1);
    check("ilv_c1_host_ack", host_ack, 0);
    advance();
    disp_req = 1'b0; disp_addr = '0;
    settle();
    check("ilv_c2_host_ack",    host_ack,    1);
    check("ilv_c2_disp_rvalid", disp_rvalid, 1);
    check("ilv_c2_disp_rdata",  disp_rdata,  32'h11);
    check("ilv_c2_host_rvalid", host_rvalid, 0);
    advance();
    idle_inputs();
    settle();
    check("ilv_c3_disp_rvalid", disp_rvalid, 1);
    check("ilv_c3_disp_rdata",  disp_rdata,  32'h22);
    check("ilv_c3_host_rvalid", host_rvalid, 0);
    advance();
    settle();
    check("ilv_c4_host_rvalid", host_rvalid, 1);
    check("ilv_c4_host_rdata",  host_rdata,  32'h33);
    check("ilv_c4_disp_rvalid", disp_rvalid, 0);
    check("ilv_c4_disp_rdata",  disp_rdata,  32'h22);
    advance();

    // Reset mid-read: the in-flight display read is dropped.
    disp_req = 1'b1; disp_addr = 4'h7;
    settle();
    check("rmr_disp_gnt", disp_gnt, 1);
    advance();
    idle_inputs();
    reset = 1'b1;
    settle();
    check("rmr_rst_disp_rvalid", disp_rvalid, 0);
    check("rmr_rst_disp_rdata",  disp_rdata,  0);
    check("rmr_rst_host_rdata",  host_rdata,  0);
    advance();
    reset = 1'b0;
    settle();
    check("rmr_rel0_disp_rvalid", disp_rvalid, 0);
    advance();
    settle();
    check("rmr_rel1_disp_rvalid", disp_rvalid, 0);
    check("rmr_rel1_disp_rdata",  disp_rdata,  0);
    advance();

    // Load both holding registers, then idle for 10 cycles.
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'h4;
    settle();
    check("idl_host_ack", host_ack, 1);
    advance();
    idle_inputs();
    disp_req = 1'b1; disp_addr = 4'h9;
    settle();
    check("idl_disp_gnt", disp_gnt, 1);
    advance();
    idle_inputs();
    settle();
    check("idl_host_rvalid", host_rvalid, 1);
    check("idl_host_rdata",  host_rdata,  32'h44);
    advance();
    settle();
    check("idl_disp_rvalid", disp_rvalid, 1);
    check("idl_disp_rdata",  disp_rdata,  32'h99);
    advance();
    for (int c = 0; c < 10; c++) begin
      settle();
      check($sformatf("idle%0d_mem_we",      c), mem_we,      0);
      check($sformatf("idle%0d_mem_addr",    c), mem_addr,    0);
      check($sformatf("idle%0d_host_rvalid", c), host_rvalid, 0);
      check($sformatf("idle%0d_disp_rvalid", c), disp_rvalid, 0);
      check($sformatf("idle%0d_host_rdata",  c), host_rdata,  32'h44);
      check($sformatf("idle%0d_disp_rdata",  c), disp_rdata,  32'h99);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
